// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: shared core constants for the fetch/decode instruction queue
package instruction_queue_pkg;
  localparam int IQ_XLEN = 32;
  localparam int IQ_DEPTH = 4;
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
endpackage

// File: rtl/instruction_queue_storage.sv
// queue_storage: register array with one write port and one asynchronous read port
module queue_storage #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output logic [W-1:0]     o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_wr_ptr] <= i_wdata;
  assign o_rdata = r_mem[i_rd_ptr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: in-order {pc, instruction} buffer between fetch and decode with flush
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int XLEN = IQ_XLEN,
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic [XLEN-1:0] i_in_instruction,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_instruction,
  output logic [PTR_W:0]  o_count
);
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             w_push, w_pop;
  logic [2*XLEN-1:0] w_rdata;
  assign o_in_ready  = r_cnt != (PTR_W+1)'(DEPTH);
  assign o_out_valid = r_cnt != '0;
  assign o_count     = r_cnt;
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;
  assign {o_out_pc, o_out_instruction} = w_rdata;
  queue_storage #(.W(2*XLEN), .DEPTH(DEPTH)) u_storage (
    .i_clk   (i_clk),
    .i_we    (w_push && !i_flush),
    .i_wr_ptr(r_wr_ptr),
    .i_wdata ({i_in_pc, i_in_instruction}),
    .i_rd_ptr(r_rd_ptr),
    .o_rdata (w_rdata)
  );
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed vector table, randomized model comparison and async reset check
module tb_instruction_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] in_pc = 0, in_instr = 0, out_pc, out_instr;
  logic [2:0]  count;
  int checks = 0, errors = 0;

  instruction_queue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_pc(in_pc), .i_in_instruction(in_instr),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_instruction(out_instr),
    .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl, v, rdy;
    logic [31:0] pc, ins;
    int cnt;
    logic ov, ir, chk_pc;
    logic [31:0] epc, eins;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(logic fl, logic v, logic rdy, logic [31:0] pc, logic [31:0] ins,
                              int cnt, logic ov, logic ir, logic cp, logic [31:0] epc, logic [31:0] eins);
    vec_t t;
    t.fl = fl; t.v = v; t.rdy = rdy; t.pc = pc; t.ins = ins;
    t.cnt = cnt; t.ov = ov; t.ir = ir; t.chk_pc = cp; t.epc = epc; t.eins = eins;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v, input logic rdy, input logic [31:0] pc, input logic [31:0] ins);
    flush = fl; in_valid = v; out_ready = rdy; in_pc = pc; in_instr = ins;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] mq[$];
  logic [31:0] pc_next;
  logic push, pop, fl, v, rdy;

  initial begin
    tbl[0]  = mk(0,1,1,32'h00,32'h00500093, 1,1,1,1,32'h00,32'h00500093);
    tbl[1]  = mk(0,1,1,32'h04,32'h00108133, 1,1,1,1,32'h04,32'h00108133);
    tbl[2]  = mk(0,1,1,32'h08,32'h00000013, 1,1,1,1,32'h08,32'h00000013);
    tbl[3]  = mk(0,0,1,32'h00,32'h0,        0,0,1,0,32'h0,32'h0);
    tbl[4]  = mk(0,1,0,32'h00,32'h00^K,     1,1,1,1,32'h00,32'h00^K);
    tbl[5]  = mk(0,1,0,32'h04,32'h04^K,     2,1,1,1,32'h00,32'h00^K);
    tbl[6]  = mk(0,1,0,32'h08,32'h08^K,     3,1,1,1,32'h00,32'h00^K);
    tbl[7]  = mk(0,1,0,32'h0C,32'h0C^K,     4,1,0,1,32'h00,32'h00^K);
    tbl[8]  = mk(0,1,0,32'h10,32'h10^K,     4,1,0,1,32'h00,32'h00^K);
    tbl[9]  = mk(0,1,1,32'h10,32'h10^K,     3,1,1,1,32'h04,32'h04^K);
    tbl[10] = mk(0,0,1,32'h00,32'h0,        2,1,1,1,32'h08,32'h08^K);
    tbl[11] = mk(0,1,1,32'h20,32'h20^K,     2,1,1,1,32'h0C,32'h0C^K);
    tbl[12] = mk(0,0,1,32'h00,32'h0,        1,1,1,1,32'h20,32'h20^K);
    tbl[13] = mk(0,1,0,32'h30,32'h30^K,     2,1,1,1,32'h20,32'h20^K);
    tbl[14] = mk(0,1,0,32'h34,32'h34^K,     3,1,1,1,32'h20,32'h20^K);
    tbl[15] = mk(1,1,1,32'h38,32'h38^K,     0,0,1,0,32'h0,32'h0);
    tbl[16] = mk(0,1,0,32'h40,32'h40^K,     1,1,1,1,32'h40,32'h40^K);
    tbl[17] = mk(0,0,1,32'h00,32'h0,        0,0,1,0,32'h0,32'h0);

    repeat (2) tick();
    chk("reset_count", 32'(count), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    rst_n = 1;
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].rdy, tbl[i].pc, tbl[i].ins);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      if (tbl[i].chk_pc) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].eins);
      end
    end
    drive(0,0,0,0,0);

    pc_next = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      chk("rand_count", 32'(count), 32'(mq.size()));
      chk("rand_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rand_in_ready", 32'(in_ready), 32'(mq.size() != 4));
      if (mq.size() != 0) begin
        chk("rand_out_pc", out_pc, mq[0][63:32]);
        chk("rand_out_instr", out_instr, mq[0][31:0]);
      end
      fl  = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = (i < 200) ? 1'(i % 2) : ($urandom_range(0, 2) == 0);
      drive(fl, v, rdy, pc_next, $urandom);
      push = v && mq.size() < 4;
      pop  = rdy && mq.size() != 0;
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({in_pc, in_instr});
      end
      if (push) pc_next += 4;
      tick();
    end

    drive(1,0,0,0,0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,32'h80 + 32'(4*i),32'h13);
      tick();
    end
    drive(0,0,0,0,0);
    chk("async_pre_count", 32'(count), 3);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1;
    tick();
    chk("post_reset_count", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Decoupling buffer between instruction fetch and decode in the RV32I core.
- Accepts {pc, instruction} pairs from fetch, holds up to DEPTH entries, and presents them in order to decode over a valid/ready handshake.
- Fetch can run ahead while decode stalls.
- A flush input discards all buffered entries on a taken branch, so wrong-path instructions never reach decode.

Parameters:
- XLEN, 32, width of pc and instruction words.
- DEPTH, 4, number of entries; must be a power of two, 2 or larger.
- PTR_W, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry.
- in_pc  input  XLEN  pc of the incoming instruction.
- in_instruction  input  XLEN  incoming instruction word.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes the head entry.
- out_pc  output  XLEN  pc of the head entry.
- out_instruction  output  XLEN  instruction word of the head entry.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries, each XLEN+XLEN bits.
- Registers:
  - write pointer wr_ptr and read pointer rd_ptr, each PTR_W bits.
  - occupancy counter cnt, PTR_W+1 bits.
- Reset (reset==0, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - out_valid=0, in_ready=1, count=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Push: in_valid && in_ready at a rising edge.
  - Store {in_pc, in_instruction} at wr_ptr.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop: out_valid && out_ready at a rising edge.
  - rd_ptr increments and wraps from DEPTH-1 to 0.
- in_ready = (cnt != DEPTH).
  - Depends only on registered state; no combinational path from out_ready to in_ready.
  - When full, a push in the same cycle as a pop is refused.
- out_valid = (cnt != 0).
  - out_pc and out_instruction are combinational reads of the entry at rd_ptr.
  - Both are don't-care when out_valid=0, but must be stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N. Minimum fall-through latency is one cycle; there is no same-cycle bypass.
- Occupancy update: cnt_next = cnt + push - pop.
  - Simultaneous push and pop at 0<cnt<DEPTH leaves cnt unchanged, with both pointers advancing.
  - At cnt==0 only a push can occur.
  - At cnt==DEPTH only a pop can occur.
- flush==1 at a rising edge:
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - A push or pop in the same cycle is ignored: the pushed entry is dropped, and the popped entry is considered consumed by decode but causes no extra state change.
  - in_ready and out_valid still follow their formulas in the flush cycle, so upstream sees normal handshake signals.
- Handshake rules (bench checks these as assertions):
  - An entry is delivered exactly once, in push order, unless flushed.
  - No entry is overwritten before it is popped.
  - count always equals pushes minus pops since the last reset or flush.
- count output = cnt.

Decomposition:
- Shared core package holds:
  - XLEN default (32).
  - RV32I NOP constant 32'h00000013, used by benches and by decode for bubble insertion.
  - Instruction-queue depth default.
- One natural sub-module: queue_storage.
  - Dual-pointer register array with one write port and one asynchronous read port.
  - Parameterised by width and depth; reusable later for a load/store buffer.
- Pointer and count logic stay in instruction_queue.

Test Plan:
- Reset and basic flow: hold reset=0 for 2 cycles, release, push pc=0x00/0x04/0x08 with instructions 0x00500093, 0x00108133, 0x00000013 while out_ready=1 -> out_valid rises one cycle after the first push; outputs appear in order; count returns to 0.
- Fill to full: out_ready=0, push 5 entries with pc=0x00..0x10 -> in_ready=0 after the 4th push, the 5th is held by fetch, count=4; the queue then drains pc 0x00, 0x04, 0x08, 0x0C in order.
- Pointer wrap: stream 10 entries with out_ready toggling 1,0,1,0 -> all 10 pcs delivered in order, none duplicated or lost, count never exceeds 4.
- Simultaneous push and pop at count=2 -> count stays 2; head advances to the next pc; the new entry appears at the tail.
- Flush with push and pop in the same cycle at count=3 -> next cycle count=0, out_valid=0, in_ready=1; the pushed entry never appears; the next push pc=0x40 is the next entry out.
- Async reset mid-stream: drive reset low between clock edges with count=3 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
